eight_by_four_unsigned_divider: RTL
===================================

// Module: eight_by_four_unsigned_divider
// PURPOSE
//  Sequential restoring divider: unsigned DIVIDEND_W-bit dividend / DIVISOR_W-bit divisor -> quotient + remainder.
//  Inverse of the four_bit_unsigned_multiplier datapath; one quotient bit resolved per clock.
//  Sits beside the multiplier in the arithmetic unit; start/done handshake toward the control FSM.
//  Interface: one clock; reset is synchronous and active-high.
// PARAMETERS
//  DIVIDEND_W  8  dividend and quotient width; also the number of iteration cycles
//  DIVISOR_W   4  divisor and remainder width
// PORTS
//  clk          in   1           rising-edge clock
//  rst          in   1           synchronous, active-high reset
//  start        in   1           request; sampled only in IDLE
//  dividend     in   DIVIDEND_W  captured on accepted start
//  divisor      in   DIVISOR_W   captured on accepted start
//  busy         out  1           high while in CALC
//  done         out  1           one-cycle pulse: results valid
//  quotient     out  DIVIDEND_W  registered result, held until the next completion
//  remainder    out  DIVISOR_W   registered result, held until the next completion
//  div_by_zero  out  1           registered flag for the last completed op; held with the results
// BEHAVIOUR
//  Reset:
//   - state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; counter and working regs cleared.
//   - Reset mid-operation aborts the op; no done pulse follows.
//  FSM states IDLE, CALC, DONE:
//   - IDLE & start & divisor!=0: latch operands, go to CALC. Counter=DIVIDEND_W, R=0, Q=dividend.
//   - IDLE & start & divisor==0: go to DONE. On this edge load quotient={DIVIDEND_W{1}}, remainder=0, div_by_zero=1.
//   - CALC, each edge:
//       R' = {R[DIVISOR_W-1:0], Q[MSB]}; Q <<= 1;
//       if R' >= D: R = R'-D, Q[0]=1; else R = R', Q[0]=0.
//       Counter decrements.
//   - CALC on the last iteration (counter==1):
//       go to DONE;
//       load quotient/remainder from the final Q/R;
//       div_by_zero=0.
//   - DONE: done=1 for exactly this cycle; next edge returns to IDLE.
//  Latency:
//   - Start edge = edge 0. Normal op: done is high in the cycle after edge DIVIDEND_W (8).
//   - Divide-by-zero: done is high in the cycle after edge 0.
//   - Back-to-back throughput: one op per DIVIDEND_W+2 cycles.
//  Width rules:
//   - Partial remainder R is DIVISOR_W+1 bits wide so the comparison never overflows.
//   - Final remainder < divisor, so it fits in DIVISOR_W bits.
//  Handshake:
//   - start while busy or in DONE is ignored; operands are not re-sampled.
//   - Operand inputs may change freely after the accept edge.
//   - quotient/remainder/div_by_zero do not change during CALC; they keep the previous result until the new one loads.
//   - start held high continuously re-triggers on each return to IDLE.
// TESTING
//  1. 200/7 -> done after 8 edges, quotient=28, remainder=4, div_by_zero=0; busy high exactly 8 cycles.
//  2. 255/15 -> q=17, r=0. 255/1 -> q=255, r=0. 5/9 -> q=0, r=5.
//  3. 100/0 -> done one cycle after start; q=8'hFF, r=0, div_by_zero=1. A following 9/3 -> q=3, r=0, div_by_zero=0.
//  4. Start 200/7, then pulse start with 50/5 at edge 3 -> ignored; result is still q=28, r=4; exactly one done pulse.
//  5. Start 200/7, assert rst at edge 4 -> all outputs 0, state IDLE, no done. A new 17/4 then gives q=4, r=1.
//  6. Randomized: all 256x16 operand pairs vs a reference model (q = a/b, r = a%b); done-pulse width = 1 cycle.

Source files
------------

// File: rtl/eight_by_four_unsigned_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/done handshake.
// Results and the divide-by-zero flag are held until the next completion.
module eight_by_four_unsigned_divider #(
  parameter int unsigned DIVIDEND_W = 8,
  parameter int unsigned DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt;
  logic [DIVISOR_W:0]    r, r_shift, r_next;
  logic [DIVIDEND_W-1:0] q, q_next;
  logic [DIVISOR_W-1:0]  d;
  logic                  last;

  // Partial remainder carries one extra bit so the trial compare cannot overflow.
  always_comb begin
    r_shift = {r[DIVISOR_W-1:0], q[DIVIDEND_W-1]};
    r_next  = r_shift;
    q_next  = {q[DIVIDEND_W-2:0], 1'b0};
    if (r_shift >= {1'b0, d}) begin
      r_next = r_shift - {1'b0, d};
      q_next = {q[DIVIDEND_W-2:0], 1'b1};
    end
  end

  assign last = (cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = (divisor == '0) ? DONE : CALC;
      CALC:    if (last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end else begin
              d   <= divisor;
              cnt <= CNT_W'(DIVIDEND_W);
              r   <= '0;
              q   <= dividend;
            end
          end
        end
        CALC: begin
          r   <= r_next;
          q   <= q_next;
          cnt <= cnt - CNT_W'(1);
          if (last) begin
            quotient    <= q_next;
            remainder   <= r_next[DIVISOR_W-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule
